rf_2r_1w_param: RTL

Parametrised successor to the fixed 32x32 two-read/one-write register file, for use as a general register bank in the GIP emulation datapath. It adds:
- configurable width and depth
- registered, enable-gated read ports with one-cycle latency
- per-lane write enables
- optional write-to-read bypass
- a post-reset hardware clear sequencer that zeroes every entry and flags busy while doing so

---
 rtl/rf_2r_1w_param.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/rf_2r_1w_param.sv
// Parametrised two-read/one-write register file with lane write enables,
// registered one-cycle reads, optional write-to-read bypass and post-reset clear.
module rf_2r_1w_param #(
    parameter int unsigned rf_width      = 32,
    parameter int unsigned rf_depth      = 32,
    parameter int unsigned rf_addr_width = 5,
    parameter int unsigned rf_lane_width = 8,
    parameter int unsigned rf_bypass     = 1
) (
    input  logic                                rf_clock,
    input  logic                                rf_reset,
    input  logic                                rf_rd_enable_0,
    input  logic [rf_addr_width-1:0]            rf_rd_addr_0,
    output logic [rf_width-1:0]                 rf_rd_data_0,
    input  logic                                rf_rd_enable_1,
    input  logic [rf_addr_width-1:0]            rf_rd_addr_1,
    output logic [rf_width-1:0]                 rf_rd_data_1,
    input  logic                                rf_wr_enable,
    input  logic [rf_addr_width-1:0]            rf_wr_addr,
    input  logic [rf_width/rf_lane_width-1:0]   rf_wr_lane_enable,
    input  logic [rf_width-1:0]                 rf_wr_data,
    output logic                                rf_busy
);

    localparam int unsigned LANES = rf_width / rf_lane_width;
    localparam int unsigned AW1   = rf_addr_width + 1;
    // One extra bit so a depth of exactly 2**rf_addr_width does not wrap to 0
    localparam logic [AW1-1:0]           DEPTH_W  = AW1'(rf_depth);
    localparam logic [rf_addr_width-1:0] LAST_PTR = rf_addr_width'(rf_depth - 1);

    if ((rf_width % rf_lane_width) != 0) begin : g_bad_lane
        $error("rf_width must be a multiple of rf_lane_width");
    end
    if ((rf_depth < 2) || (rf_depth > (1 << rf_addr_width))) begin : g_bad_depth
        $error("rf_depth out of range for rf_addr_width");
    end

    typedef enum logic {
        ST_CLEARING = 1'b0,
        ST_READY    = 1'b1
    } state_t;

    state_t                     r_state;
    state_t                     w_state_nxt;
    logic [rf_addr_width-1:0]   r_clr_ptr;
    logic [rf_addr_width-1:0]   w_clr_ptr_nxt;
    logic                       r_busy;
    logic                       w_busy_nxt;
    logic [rf_width-1:0]        r_rd_data_0;
    logic [rf_width-1:0]        r_rd_data_1;
    logic [rf_width-1:0]        w_rd_nxt_0;
    logic [rf_width-1:0]        w_rd_nxt_1;
    logic [rf_width-1:0]        w_rd_val_0;
    logic [rf_width-1:0]        w_rd_val_1;
    logic [rf_width-1:0]        w_wr_merged;
    logic                       w_wr_in_range;
    logic                       w_rd_in_range_0;
    logic                       w_rd_in_range_1;
    logic                       w_clr_we;
    logic                       w_wr_we;
    logic [rf_width-1:0]        r_mem [rf_depth];

    assign w_wr_in_range   = {1'b0, rf_wr_addr}   < DEPTH_W;
    assign w_rd_in_range_0 = {1'b0, rf_rd_addr_0} < DEPTH_W;
    assign w_rd_in_range_1 = {1'b0, rf_rd_addr_1} < DEPTH_W;

    assign w_clr_we = rf_reset && (r_state == ST_CLEARING);
    assign w_wr_we  = rf_reset && (r_state == ST_READY) && rf_wr_enable && w_wr_in_range;

    // State register: sequencer state, clear pointer, busy flag, read outputs
    always_ff @(posedge rf_clock) begin
        r_state     <= w_state_nxt;
        r_clr_ptr   <= w_clr_ptr_nxt;
        r_busy      <= w_busy_nxt;
        r_rd_data_0 <= w_rd_nxt_0;
        r_rd_data_1 <= w_rd_nxt_1;
    end

    // Next state: reset restarts the clear walk; READY once the last entry is zeroed
    always_comb begin
        w_state_nxt   = r_state;
        w_clr_ptr_nxt = r_clr_ptr;
        w_busy_nxt    = r_busy;
        if (!rf_reset) begin
            w_state_nxt   = ST_CLEARING;
            w_clr_ptr_nxt = '0;
            w_busy_nxt    = 1'b1;
        end else if (r_state == ST_CLEARING) begin
            if (r_clr_ptr == LAST_PTR) begin
                w_state_nxt = ST_READY;
                w_busy_nxt  = 1'b0;
            end else begin
                w_clr_ptr_nxt = r_clr_ptr + rf_addr_width'(1);
            end
        end
    end

    // Lane merge of write data over the addressed entry
    always_comb begin
        w_wr_merged = r_mem[rf_wr_addr];
        for (int unsigned i = 0; i < LANES; i++) begin
            if (rf_wr_lane_enable[i]) begin
                w_wr_merged[i*rf_lane_width +: rf_lane_width] =
                    rf_wr_data[i*rf_lane_width +: rf_lane_width];
            end
        end
    end

    // Output logic: read values (with optional bypass) and next read registers
    always_comb begin
        w_rd_val_0 = '0;
        w_rd_val_1 = '0;
        if (w_rd_in_range_0) begin
            if ((rf_bypass != 0) && w_wr_we && (rf_rd_addr_0 == rf_wr_addr)) begin
                w_rd_val_0 = w_wr_merged;
            end else begin
                w_rd_val_0 = r_mem[rf_rd_addr_0];
            end
        end
        if (w_rd_in_range_1) begin
            if ((rf_bypass != 0) && w_wr_we && (rf_rd_addr_1 == rf_wr_addr)) begin
                w_rd_val_1 = w_wr_merged;
            end else begin
                w_rd_val_1 = r_mem[rf_rd_addr_1];
            end
        end

        w_rd_nxt_0 = r_rd_data_0;
        w_rd_nxt_1 = r_rd_data_1;
        if (!rf_reset || (r_state != ST_READY)) begin
            w_rd_nxt_0 = '0;
            w_rd_nxt_1 = '0;
        end else begin
            if (rf_rd_enable_0) begin
                w_rd_nxt_0 = w_rd_val_0;
            end
            if (rf_rd_enable_1) begin
                w_rd_nxt_1 = w_rd_val_1;
            end
        end
    end

    // Storage array; reset leaves it alone, the clear walk zeroes it
    always_ff @(posedge rf_clock) begin
        if (w_clr_we) begin
            r_mem[r_clr_ptr] <= '0;
        end else if (w_wr_we) begin
            r_mem[rf_wr_addr] <= w_wr_merged;
        end
    end

    assign rf_rd_data_0 = r_rd_data_0;
    assign rf_rd_data_1 = r_rd_data_1;
    assign rf_busy      = r_busy;

endmodule
